// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_e;

  localparam int MAX_NREQ   = 8;
  localparam int STAT_CNT_W = 16;
  localparam int STAT_TO_W  = 8;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_arb_rr.sv
// Combinational round-robin picker: first set candidate at or after ptr_i,
// wrapping to the lowest index.
module uart_arb_rr
  import uart_arb_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  cand_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic             found_hi, found_lo;
  logic [IDX_W-1:0] hi_idx, lo_idx;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_hi && cand_i[i] && (i >= int'(ptr_i))) begin
        found_hi = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (!found_lo && cand_i[i] && (i < int'(ptr_i))) begin
        found_lo = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
  end

  assign any_o  = found_hi | found_lo;
  assign idx_o  = found_hi ? hi_idx : lo_idx;
  assign pick_o = any_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources,
// with per-source message lock. Optional counters under UART_ARB_STATS_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][7:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic [NREQ-1:0]      grant,
  output logic                 err_timeout
`ifdef UART_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][STAT_CNT_W-1:0] stat_count,
  output logic [STAT_TO_W-1:0]            stat_timeouts
`endif
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             lock_q, lock_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [NREQ-1:0]  owner_oh;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             accept;
  logic             tmo_hit;

  assign owner_oh = NREQ'(1) << owner_q;
  assign cand     = lock_q ? (req_valid & owner_oh) : req_valid;

  uart_arb_rr #(.NREQ(NREQ)) u_rr (
    .cand_i (cand),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // A transfer needs an idle FSM and an idle UART; reset blocks it outright.
  assign accept  = (state_q == IDLE) && pick_any && !tx_busy && !reset;
  assign tmo_hit = (state_q == WAIT_HI) && !tx_busy &&
                   (tmo_cnt_q == TMO_W'(BUSY_TIMEOUT));

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy)      state_d = WAIT_LO;
        else if (tmo_hit) state_d = IDLE;
      end
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = accept ? pick : '0;
    tx_send     = (state_q == SEND);
    err_timeout = tmo_hit;
    grant       = ((state_q != IDLE) || lock_q) ? owner_oh : '0;
    tx_data     = tx_data_q;
  end

  always_comb begin
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    ptr_d     = ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    if (accept) begin
      tx_data_d = req_data[pick_idx];
      owner_d   = pick_idx;
      if (req_last[pick_idx]) begin
        lock_d = 1'b0;
        ptr_d  = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
      end else begin
        lock_d = 1'b1;
      end
    end
    if (state_q == SEND) begin
      tmo_cnt_d = '0;
    end else if ((state_q == WAIT_HI) && !tx_busy && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_q <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      ptr_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      ptr_q     <= ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

`ifdef UART_ARB_STATS_EN
  logic                                 byte_done;
  logic [NREQ-1:0][STAT_CNT_W-1:0]      stat_count_q;
  logic [STAT_TO_W-1:0]                 stat_timeouts_q;

  // A byte counts only once the UART has actually finished shifting it.
  assign byte_done = (state_q == WAIT_LO) && !tx_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_count_q    <= '0;
      stat_timeouts_q <= '0;
    end else begin
      if (byte_done && (stat_count_q[owner_q] != '1))
        stat_count_q[owner_q] <= stat_count_q[owner_q] + STAT_CNT_W'(1);
      if (tmo_hit && (stat_timeouts_q != '1))
        stat_timeouts_q <= stat_timeouts_q + STAT_TO_W'(1);
    end
  end

  assign stat_count    = stat_count_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UART busy model.
// Define UART_ARB_STATS_EN to also exercise the statistics counters.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 2;
  localparam int L_ACC = 0;
  localparam int L_SND = 1;
  localparam int L_TMO = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0][7:0] req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic [7:0]           tx_data;
  logic                 tx_send;
  logic                 tx_busy = 1'b0;
  logic [NREQ-1:0]      grant;
  logic                 err_timeout;
`ifdef UART_ARB_STATS_EN
  logic [NREQ-1:0][15:0] stat_count;
  logic [7:0]            stat_timeouts;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [8:0] srcq0[$];
  logic [8:0] srcq1[$];
  int  busy_left = 0;
  bit  busy_en = 1'b1;
  bit  prev_busy = 1'b0;
  int  fall_cyc = -1;

  int              acc_cyc[$];
  logic [7:0]      acc_data[$];
  logic [NREQ-1:0] acc_grant[$];
  int              snd_cyc[$];
  logic [7:0]      snd_data[$];
  logic [NREQ-1:0] snd_grant[$];
  int              tmo_cyc[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .err_timeout (err_timeout)
`ifdef UART_ARB_STATS_EN
    ,
    .stat_count    (stat_count),
    .stat_timeouts (stat_timeouts)
`endif
  );

  // Monitor: observes mid-cycle, logs transfers, strobes and timeouts.
  always @(negedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (req_valid[r] && req_ready[r]) begin
        acc_cyc.push_back(cyc);
        acc_data.push_back(req_data[r]);
        acc_grant.push_back(grant);
        if (r == 0) srcq0.delete(0);
        else        srcq1.delete(0);
      end
    end
    if (tx_send) begin
      snd_cyc.push_back(cyc);
      snd_data.push_back(tx_data);
      snd_grant.push_back(grant);
      if (busy_en) busy_left = 10;
    end
    if (err_timeout) tmo_cyc.push_back(cyc);
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
  end

  // Driver: busy model and source presentation, just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
    req_valid[0] = (srcq0.size() != 0);
    if (srcq0.size() != 0) {req_last[0], req_data[0]} = srcq0[0];
    req_valid[1] = (srcq1.size() != 0);
    if (srcq1.size() != 0) {req_last[1], req_data[1]} = srcq1[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic int log_size(input int sel);
    case (sel)
      L_ACC:   return acc_cyc.size();
      L_SND:   return snd_cyc.size();
      default: return tmo_cyc.size();
    endcase
  endfunction

  task automatic wait_for(input int sel, input int n, input int budget, input string tag);
    int k = 0;
    while ((log_size(sel) < n) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    check(tag, 32'(log_size(sel)), 32'(n));
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    acc_data.delete();
    acc_grant.delete();
    snd_cyc.delete();
    snd_data.delete();
    snd_grant.delete();
    tmo_cyc.delete();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    srcq0.delete();
    srcq1.delete();
    busy_left = 0;
    tx_busy   = 1'b0;
    at_neg();
    check({tag, "_ready"},   32'(req_ready),   32'h0);
    check({tag, "_send"},    32'(tx_send),     32'h0);
    check({tag, "_data"},    32'(tx_data),     32'h0);
    check({tag, "_grant"},   32'(grant),       32'h0);
    check({tag, "_timeout"}, 32'(err_timeout), 32'h0);
`ifdef UART_ARB_STATS_EN
    check({tag, "_stat0"},   32'(stat_count[0]), 32'h0);
    check({tag, "_stat_to"}, 32'(stat_timeouts), 32'h0);
`endif
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    do_reset("rst0");

    // Single byte: ready at N, strobe at N+1, grant held, next accept after busy falls.
    srcq0.push_back({1'b1, 8'h41});
    at_neg();
    check("t1_ready", 32'(req_ready), 32'h1);
    at_neg();
    check("t1_send",  32'(tx_send), 32'h1);
    check("t1_data",  32'(tx_data), 32'h41);
    check("t1_grant", 32'(grant),   32'h1);
    repeat (5) at_neg();
    check("t1_grant_hold", 32'(grant), 32'h1);
    srcq0.push_back({1'b1, 8'h42});
    at_neg();
    check("t1_stall", 32'(req_ready), 32'h0);
    wait_for(L_ACC, 2, 40, "t1_acc2");
    check("t1_latency", 32'(snd_cyc[0] - acc_cyc[0]), 32'd1);
    check("t1_next_accept", 32'(acc_cyc[1] - fall_cyc), 32'd1);
    wait_for(L_SND, 2, 40, "t1_snd2");
    check("t1_data2", 32'(snd_data[1]), 32'h42);
    idle(16);

    // Two sources continuously valid: strict alternation.
    do_reset("rst1");
    srcq0.push_back({1'b1, 8'h10});
    srcq0.push_back({1'b1, 8'h11});
    srcq1.push_back({1'b1, 8'h20});
    srcq1.push_back({1'b1, 8'h21});
    wait_for(L_SND, 4, 120, "t2_sends");
    check("t2_b0", 32'(snd_data[0]), 32'h10);
    check("t2_b1", 32'(snd_data[1]), 32'h20);
    check("t2_b2", 32'(snd_data[2]), 32'h11);
    check("t2_b3", 32'(snd_data[3]), 32'h21);
    idle(16);

    // Message lock: req1's three-byte message is not interleaved with req0.
    clear_logs();
    srcq0.push_back({1'b1, 8'h30});
    srcq0.push_back({1'b1, 8'h31});
    srcq1.push_back({1'b0, 8'hAA});
    srcq1.push_back({1'b0, 8'hBB});
    srcq1.push_back({1'b1, 8'hCC});
    wait_for(L_SND, 5, 150, "t3_sends");
    check("t3_b0", 32'(snd_data[0]), 32'h30);
    check("t3_b1", 32'(snd_data[1]), 32'hAA);
    check("t3_b2", 32'(snd_data[2]), 32'hBB);
    check("t3_b3", 32'(snd_data[3]), 32'hCC);
    check("t3_b4", 32'(snd_data[4]), 32'h31);
    check("t3_idle_grant_aa", 32'(acc_grant[1]), 32'h0);
    check("t3_idle_grant_bb", 32'(acc_grant[2]), 32'h2);
    check("t3_idle_grant_cc", 32'(acc_grant[3]), 32'h2);
    check("t3_idle_grant_31", 32'(acc_grant[4]), 32'h0);
    check("t3_send_grant_bb", 32'(snd_grant[2]), 32'h2);
    check("t3_send_grant_31", 32'(snd_grant[4]), 32'h1);
    idle(16);

    // Busy never rises: timeout 17 cycles after the strobe, then recovery.
    clear_logs();
    busy_en = 1'b0;
    srcq0.push_back({1'b1, 8'h55});
    wait_for(L_SND, 1, 40, "t4_snd1");
    busy_en = 1'b1;
    srcq0.push_back({1'b1, 8'h56});
    wait_for(L_TMO, 1, 40, "t4_tmo");
    check("t4_tmo_delay", 32'(tmo_cyc[0] - snd_cyc[0]), 32'd17);
    wait_for(L_ACC, 2, 40, "t4_acc2");
    check("t4_recover", 32'(acc_cyc[1] - tmo_cyc[0]), 32'd1);
    check("t4_data2", 32'(acc_data[1]), 32'h56);
    idle(20);
    check("t4_pulses", 32'(tmo_cyc.size()), 32'd1);

    // Reset in WAIT_LO while req1 holds the lock.
    clear_logs();
    srcq1.push_back({1'b0, 8'hE1});
    srcq0.push_back({1'b1, 8'h70});
    wait_for(L_SND, 1, 40, "t5_snd1");
    check("t5_first", 32'(snd_data[0]), 32'hE1);
    at_neg();
    at_neg();
    check("t5_grant_locked", 32'(grant), 32'h2);
    do_reset("t5_rst");
    srcq0.push_back({1'b1, 8'h71});
    srcq1.push_back({1'b1, 8'hF1});
    wait_for(L_SND, 2, 60, "t5_sends");
    check("t5_b0", 32'(snd_data[0]), 32'h71);
    check("t5_b1", 32'(snd_data[1]), 32'hF1);
    check("t5_unlocked", 32'(acc_grant[0]), 32'h0);
    idle(16);

`ifdef UART_ARB_STATS_EN
    // Five completed bytes and one timeout.
    do_reset("t6_rst");
    for (int i = 0; i < 5; i++) srcq0.push_back({1'b1, 8'(8'h80 + i)});
    wait_for(L_SND, 5, 150, "t6_sends");
    idle(16);
    busy_en = 1'b0;
    srcq0.push_back({1'b1, 8'h66});
    wait_for(L_TMO, 1, 60, "t6_tmo");
    idle(4);
    busy_en = 1'b1;
    check("t6_count0",   32'(stat_count[0]), 32'd5);
    check("t6_count1",   32'(stat_count[1]), 32'd0);
    check("t6_timeouts", 32'(stat_timeouts), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter in the host board's UART I/O block between NREQ byte sources, e.g. the Z80 I/O-port writer and the host monitor/message ROM. Each source sends bytes over a valid/ready handshake. The arbiter picks one source round-robin and issues one-cycle send strobes to the UART core. It then tracks the core's busy flag until the byte has gone out. A per-source message lock keeps multi-byte messages from interleaving.

Parameters:
NREQ, 2, number of requesters (2..8)
BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_send before aborting

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester byte valid
req_data  in  NREQ x 8  per-requester byte
req_last  in  NREQ  byte ends a message; 0 keeps the lock
req_ready  out  NREQ  byte accepted this cycle (valid & ready = transfer)
tx_data  out  8  byte to UART core, held stable from the send cycle until IDLE
tx_send  out  1  one-cycle start strobe to UART core
tx_busy  in  1  UART core busy, high while shifting
grant  out  NREQ  one-hot current owner, or 0 when no owner
err_timeout  out  1  one-cycle pulse when tx_busy never rose

Behaviour:
- Clock is clk. Reset is reset, synchronous and active-high. Both are fixed.
- Reset values:
  - state = IDLE
  - tx_data = 0, tx_send = 0, grant = 0, req_ready = 0, err_timeout = 0
  - lock cleared
  - round-robin pointer = 0, so requester 0 has highest priority
- Reset mid-byte abandons the byte. tx_send is never reasserted for it.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE, selection:
  - Candidate set is req_valid, restricted to the lock owner when locked.
  - Select the first candidate at or after the pointer, mod NREQ.
  - req_ready is combinational: one-hot on the selected requester, only when tx_busy == 0. All zeros otherwise.
- IDLE, on transfer:
  - Register tx_data.
  - Set grant to the selected requester.
  - If req_last = 0, set lock = owner. If req_last = 1, clear lock and set pointer = owner + 1 mod NREQ.
  - Go to SEND.
- SEND: tx_send = 1 for exactly this cycle. Clear timeout counter. Go to WAIT_HI.
- WAIT_HI:
  - tx_busy = 1: go to WAIT_LO.
  - Counter reaches BUSY_TIMEOUT: pulse err_timeout, go to IDLE. Lock and pointer updates stand.
- WAIT_LO: tx_busy = 0: go to IDLE.
- Timing:
  - Byte accepted in cycle N gives tx_send high in N+1.
  - Next byte can be accepted in the cycle after tx_busy falls, i.e. the cycle the FSM is back in IDLE.
- grant:
  - Holds the owner from SEND through WAIT_LO.
  - Holds while locked, including in IDLE.
  - Clears in IDLE once unlocked.
- Locked owner with req_valid = 0: stays locked indefinitely. Other requesters stall.
- Simultaneous valids: only the selected requester sees req_ready; the others hold their data.
- tx_busy high in IDLE: no transfer accepted; wait for it to go low.
- NREQ = 1 degenerates to a pass-through with the same timing.

Optional Feature:
UART_ARB_STATS_EN
- Defined:
  - Adds output stat_count, NREQ x 16.
  - Per-requester saturating count of bytes completed, i.e. reached WAIT_LO then IDLE. Timeouts are not counted.
  - Adds output stat_timeouts, 8 bits, saturating.
  - All counters are cleared by reset.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Decomposition:
- Package uart_arb_pkg: FSM state enum (IDLE, SEND, WAIT_HI, WAIT_LO), NREQ maximum constant (8), counter widths (16, 8).
- Sub-module uart_arb_rr: purely combinational round-robin picker.
  - Inputs: candidate mask, pointer.
  - Outputs: one-hot pick, index, any.

Test Plan:
1. Single byte, busy model rises 1 cycle after tx_send for 10 cycles: req 0 sends 0x41 -> req_ready[0] at N, tx_send at N+1 with tx_data=0x41, grant=01 until IDLE, next accept at busy-fall+1.
2. Both valid continuously, req0 bytes 0x10.., req1 bytes 0x20.., all last=1 -> UART sees 0x10,0x20,0x11,0x21 (strict alternation).
3. Req1 sends 0xAA,0xBB,0xCC with last=0,0,1 while req0 is valid -> three consecutive req1 bytes, grant=10 throughout, then req0 served.
4. Busy model never asserts -> err_timeout pulses exactly 17 cycles after tx_send (16-cycle count, 1-cycle state exit), FSM back in IDLE, next byte accepted.
5. Reset asserted during WAIT_LO with lock held -> next cycle all outputs 0, lock cleared, req0 wins over req1 when both valid.
6. With UART_ARB_STATS_EN defined: 5 bytes from req0 and 1 timeout -> stat_count[0]=5, stat_timeouts=1.
